// File: rtl/vpu_fwd_pkg.sv
// Shared constants and types for the vector forwarding stage.
package vpu_fwd_pkg;

    localparam int LANES     = 8;
    localparam int EW        = 64;
    localparam int VREG_BITS = 5;
    localparam int VER_BITS  = 4;
    localparam int TAGW      = VREG_BITS + VER_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fwd_state_t;

    typedef logic [TAGW-1:0] tag_t;

endpackage

// File: rtl/vpu_lane_collect.sv
// One lane's result register and completion flag.
module vpu_lane_collect
    import vpu_fwd_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_cap_en,
    input  logic [EW-1:0] i_data,
    output logic [EW-1:0] o_data,
    output logic          o_done
);

    logic [EW-1:0] r_data;
    logic          r_done;

    // Clear wins over capture so a fresh op always starts from zeroed lanes.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_data <= '0;
            r_done <= 1'b0;
        end else if (i_cap_en) begin
            r_data <= i_data;
            r_done <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_done = r_done;

endmodule

// File: rtl/vpu_fwd_stage.sv
// Result-holding forwarding stage: collects out-of-order lane results and forwards them.
// Optional macro VPU_FWD_PARTIAL_EN forwards each lane as soon as it completes.
module vpu_fwd_stage
    import vpu_fwd_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [TAGW-1:0]     issue_tag,
    input  logic [LANES-1:0]    issue_mask,
    input  logic [LANES-1:0]    res_valid,
    input  logic [LANES*EW-1:0] res_data,
    output logic [TAGW-1:0]     fwd_tag,
    output logic [LANES-1:0]    fwd_valid_mask,
    output logic [LANES*EW-1:0] fwd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TAGW-1:0]     out_tag,
    output logic [LANES-1:0]    out_mask,
    output logic [LANES*EW-1:0] out_data,
    output logic                busy
);

    fwd_state_t          r_state;
    fwd_state_t          w_stateNext;
    tag_t                r_tag;
    tag_t                w_tagNext;
    logic [LANES-1:0]    r_mask;
    logic [LANES-1:0]    w_maskNext;
    logic [LANES-1:0]    r_fwdMask;
    logic [LANES-1:0]    w_fwdMaskNext;
    logic                r_outValid;
    logic                r_busy;
    logic                w_issueFire;
    logic                w_clearLanes;
    logic [LANES-1:0]    w_capEn;
    logic [LANES-1:0]    w_done;
    logic [LANES-1:0]    w_doneNext;
    logic [LANES*EW-1:0] w_laneData;

    assign issue_ready = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign w_issueFire = issue_ready && issue_valid;

    // Only FILL captures; the issue edge itself never leaves FILL, so it is excluded naturally.
    assign w_capEn    = (r_state == FILL) ? (res_valid & r_mask & ~w_done) : '0;
    assign w_doneNext = w_done | w_capEn;

    // Lanes are zeroed on a new issue and whenever the stage falls back to IDLE.
    assign w_clearLanes = w_issueFire || ((r_state == DONE) && out_ready);

    genvar l;
    generate
        for (l = 0; l < LANES; l++) begin : g_lane
            vpu_lane_collect u_lane (
                .clk      (clk),
                .rst      (rst),
                .i_clear  (w_clearLanes),
                .i_cap_en (w_capEn[l]),
                .i_data   (res_data[l*EW +: EW]),
                .o_data   (w_laneData[l*EW +: EW]),
                .o_done   (w_done[l])
            );
        end
    endgenerate

    always_comb begin
        w_stateNext = r_state;
        w_tagNext   = r_tag;
        w_maskNext  = r_mask;
        unique case (r_state)
            IDLE: begin
                if (w_issueFire) begin
                    w_stateNext = (issue_mask == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (w_doneNext == r_mask) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (w_issueFire) begin
                    w_stateNext = (issue_mask == '0) ? DONE : FILL;
                end else if (out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase

        if (w_issueFire) begin
            w_tagNext  = issue_tag;
            w_maskNext = issue_mask;
        end else if (w_stateNext == IDLE) begin
            w_tagNext  = '0;
            w_maskNext = '0;
        end
    end

    // Forward-mask is computed from the next state so the output register tracks it exactly.
    always_comb begin
        w_fwdMaskNext = '0;
        if (w_stateNext == DONE) begin
            w_fwdMaskNext = w_maskNext;
        end else if (w_stateNext == FILL && !w_issueFire) begin
`ifdef VPU_FWD_PARTIAL_EN
            w_fwdMaskNext = w_doneNext & r_mask;
`else
            w_fwdMaskNext = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tag      <= '0;
            r_mask     <= '0;
            r_fwdMask  <= '0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_tag      <= w_tagNext;
            r_mask     <= w_maskNext;
            r_fwdMask  <= w_fwdMaskNext;
            r_outValid <= (w_stateNext == DONE);
            r_busy     <= (w_stateNext != IDLE);
        end
    end

    assign fwd_tag        = r_tag;
    assign fwd_valid_mask = r_fwdMask;
    assign fwd_data       = w_laneData;
    assign out_valid      = r_outValid;
    assign out_tag        = r_tag;
    assign out_mask       = r_mask;
    assign out_data       = w_laneData;
    assign busy           = r_busy;

endmodule

// File: tb/tb_vpu_fwd_stage.sv
// Directed self-checking bench for vpu_fwd_stage.
module tb_vpu_fwd_stage;
    import vpu_fwd_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                issue_valid;
    logic                issue_ready;
    logic [TAGW-1:0]     issue_tag;
    logic [LANES-1:0]    issue_mask;
    logic [LANES-1:0]    res_valid;
    logic [LANES*EW-1:0] res_data;
    logic [TAGW-1:0]     fwd_tag;
    logic [LANES-1:0]    fwd_valid_mask;
    logic [LANES*EW-1:0] fwd_data;
    logic                out_valid;
    logic                out_ready;
    logic [TAGW-1:0]     out_tag;
    logic [LANES-1:0]    out_mask;
    logic [LANES*EW-1:0] out_data;
    logic                busy;

    int vectorCount = 0;
    int missCount   = 0;

    logic [LANES*EW-1:0] expData;
    logic [LANES-1:0]    partialMask;

    vpu_fwd_stage dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_tag      (issue_tag),
        .issue_mask     (issue_mask),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .fwd_tag        (fwd_tag),
        .fwd_valid_mask (fwd_valid_mask),
        .fwd_data       (fwd_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_tag        (out_tag),
        .out_mask       (out_mask),
        .out_data       (out_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [LANES*EW-1:0] observed,
                               input logic [LANES*EW-1:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
`ifdef VPU_FWD_PARTIAL_EN
        partialMask = 8'hFF;
`else
        partialMask = 8'h00;
`endif
        rst         = 1'b1;
        issue_valid = 1'b1;
        issue_tag   = 9'h1FF;
        issue_mask  = 8'hFF;
        res_valid   = '0;
        res_data    = '0;
        out_ready   = 1'b0;

        // Reset held with a pending issue.
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("rst_issue_ready", issue_ready, 0);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_fwd_mask", fwd_valid_mask, 0);
            checkOutput("rst_busy", busy, 0);
        end
        rst         = 1'b0;
        issue_valid = 1'b0;
        #1;
        checkOutput("post_rst_issue_ready", issue_ready, 1);
        applyStimulus();

        // Out-of-order fill.
        issue_valid = 1'b1;
        issue_tag   = 9'h0A3;
        issue_mask  = 8'hFF;
        for (int l = 0; l < LANES; l++) res_data[l*EW +: EW] = 64'(l + 1);
        applyStimulus();
        issue_valid = 1'b0;
        checkOutput("ooo_busy", busy, 1);
        checkOutput("ooo_fwd_tag", fwd_tag, 9'h0A3);
        checkOutput("ooo_fwd_mask0", fwd_valid_mask, 0);
        checkOutput("ooo_out_valid0", out_valid, 0);
        res_valid = 8'h0F;
        applyStimulus();
        checkOutput("ooo_fwd_mask1", fwd_valid_mask, 8'h0F & partialMask);
        checkOutput("ooo_fwd_lane0", fwd_data[EW-1:0], 1);
        checkOutput("ooo_fwd_lane4", fwd_data[4*EW +: EW], 0);
        checkOutput("ooo_out_valid1", out_valid, 0);
        res_valid = 8'hF0;
        applyStimulus();
        res_valid = 8'h00;
        checkOutput("ooo_out_valid2", out_valid, 1);
        checkOutput("ooo_fwd_mask2", fwd_valid_mask, 8'hFF);
        checkOutput("ooo_lane7", out_data[7*EW +: EW], 8);
        checkOutput("ooo_out_tag", out_tag, 9'h0A3);
        checkOutput("ooo_out_mask", out_mask, 8'hFF);
        out_ready = 1'b1;
        applyStimulus();
        out_ready = 1'b0;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_out_valid", out_valid, 0);
        checkOutput("idle_fwd_tag", fwd_tag, 0);
        checkOutput("idle_fwd_data", fwd_data, 0);

        // Masked lanes.
        issue_valid = 1'b1;
        issue_tag   = 9'h111;
        issue_mask  = 8'h55;
        applyStimulus();
        issue_valid = 1'b0;
        res_valid   = 8'hFF;
        for (int l = 0; l < LANES; l++) res_data[l*EW +: EW] = 64'hDEAD;
        applyStimulus();
        expData = '0;
        for (int l = 0; l < LANES; l += 2) expData[l*EW +: EW] = 64'hDEAD;
        checkOutput("mask_out_valid", out_valid, 1);
        checkOutput("mask_out_data", out_data, expData);
        checkOutput("mask_fwd_mask", fwd_valid_mask, 8'h55);
        res_valid = 8'h01;
        res_data[EW-1:0] = 64'hBEEF;
        applyStimulus();
        res_valid = 8'h00;
        checkOutput("mask_no_overwrite", out_data, expData);

        // Backpressure.
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_out_tag", out_tag, 9'h111);
            checkOutput("bp_out_data", out_data, expData);
            checkOutput("bp_issue_ready", issue_ready, 0);
        end

        // Back-to-back issue on the output handshake.
        out_ready   = 1'b1;
        issue_valid = 1'b1;
        issue_tag   = 9'h1C2;
        issue_mask  = 8'h03;
        #1;
        checkOutput("b2b_issue_ready", issue_ready, 1);
        applyStimulus();
        out_ready   = 1'b0;
        issue_valid = 1'b0;
        checkOutput("b2b_busy", busy, 1);
        checkOutput("b2b_fwd_tag", fwd_tag, 9'h1C2);
        checkOutput("b2b_out_valid", out_valid, 0);
        checkOutput("b2b_fwd_data", fwd_data, 0);
        res_valid = 8'h06;
        res_data  = '0;
        res_data[1*EW +: EW] = 64'h22;
        res_data[2*EW +: EW] = 64'h33;
        applyStimulus();
        checkOutput("b2b_fwd_mask1", fwd_valid_mask, 8'h02 & partialMask);
        checkOutput("b2b_out_valid1", out_valid, 0);
        res_valid = 8'h03;
        res_data[0*EW +: EW] = 64'h11;
        res_data[1*EW +: EW] = 64'h99;
        applyStimulus();
        res_valid = 8'h00;
        expData = '0;
        expData[0*EW +: EW] = 64'h11;
        expData[1*EW +: EW] = 64'h22;
        checkOutput("b2b_out_valid2", out_valid, 1);
        checkOutput("b2b_out_data", out_data, expData);

        // Zero mask issued back-to-back.
        out_ready   = 1'b1;
        issue_valid = 1'b1;
        issue_tag   = 9'h0FF;
        issue_mask  = 8'h00;
        applyStimulus();
        issue_valid = 1'b0;
        checkOutput("zero_out_valid", out_valid, 1);
        checkOutput("zero_out_data", out_data, 0);
        checkOutput("zero_out_tag", out_tag, 9'h0FF);
        checkOutput("zero_out_mask", out_mask, 0);
        applyStimulus();
        out_ready = 1'b0;
        checkOutput("zero_idle", out_valid, 0);

        // Reset mid-FILL.
        issue_valid = 1'b1;
        issue_tag   = 9'h055;
        issue_mask  = 8'hFF;
        applyStimulus();
        issue_valid = 1'b0;
        res_valid   = 8'h07;
        for (int l = 0; l < LANES; l++) res_data[l*EW +: EW] = 64'(16 + l);
        applyStimulus();
        res_valid = 8'h00;
        checkOutput("mid_fwd_lane2", fwd_data[2*EW +: EW], 18);
        rst = 1'b1;
        applyStimulus();
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_fwd_mask", fwd_valid_mask, 0);
        checkOutput("mid_rst_fwd_tag", fwd_tag, 0);
        checkOutput("mid_rst_fwd_data", fwd_data, 0);
        checkOutput("mid_rst_issue_ready", issue_ready, 0);
        rst       = 1'b0;
        res_valid = 8'hF8;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("abort_out_valid", out_valid, 0);
            checkOutput("abort_busy", busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
